seq_divider: RTL and testbench

Sequential 16-bit unsigned restoring divider for the processor datapath, paired with the combinational SUB unit. Each iteration is one trial subtraction using SUB's flag convention: carry=1 means no borrow, i.e. minuend >= subtrahend. It accepts one operation per start pulse, iterates one quotient bit per clock, and reports quotient, remainder and a divide-by-zero flag with a done pulse. It is the multi-cycle arithmetic unit that the control FSM stalls on.

---
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Divide-by-zero skips iteration and completes on the accept edge.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             carry;
  logic [WIDTH:0]   prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             last_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Trial subtraction one bit wider than the remainder; carry=1 means no borrow.
  always_comb begin
    shifted   = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff      = {1'b0, shifted} - {2'b00, dvs_q};
    carry     = ~diff[WIDTH+1];
    prem_nxt  = carry ? diff[WIDTH:0] : shifted;
    dvd_nxt   = {dvd_q[WIDTH-2:0], carry};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor != '0) ? RUN : DONE;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prem_d = prem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d  = dividend;
            dvs_d  = divisor;
            prem_d = '0;
            cnt_d  = '0;
          end else begin
            quo_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end
        end
      end
      RUN: begin
        prem_d = prem_nxt;
        dvd_d  = dvd_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          quo_d = dvd_nxt;
          rem_d = prem_nxt[WIDTH-1:0];
          dbz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, corner-case
// sequences, and random operations checked against plain integer division.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division, all ones / dividend on zero divisor.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic z);
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Waits (bounded) for done after the accept edge, checks timing and results.
  task automatic wait_done(input string name, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    int lat = 0;
    int bcnt = 0;
    int overlap = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (busy && done) overlap++;
    chk({name, "_latency"}, lat, (b == 16'd0) ? 0 : 16);
    chk({name, "_busy_cycles"}, bcnt, (b == 16'd0) ? 0 : 16);
    chk({name, "_busy_done_overlap"}, overlap, 0);
    chk({name, "_quotient"}, quotient, eq);
    chk({name, "_remainder"}, remainder, er);
    chk({name, "_dbz"}, div_by_zero, edbz);
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    wait_done(name, b, eq, er, edbz);
    tick();
    chk({name, "_done_falls"}, done, 1'b0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    logic [15:0] mq, mr, a, b;
    logic mz;
    int done_seen;

    vecs[0] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0};
    vecs[3] = '{16'h0002, 16'h0004, 16'h0000, 16'h0002, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0};
    vecs[5] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[6] = '{16'h0009, 16'h0003, 16'h0003, 16'h0000, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    dividend = 16'h0;
    divisor = 16'h0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_quotient", quotient, 16'h0);
    chk("reset_remainder", remainder, 16'h0);
    chk("reset_dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edbz);

    // Second start during RUN with new operands must be ignored.
    dividend = 16'h0064;
    divisor  = 16'h0007;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    dividend = 16'h0010;
    divisor  = 16'h0002;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored_start_busy", busy, 1'b1);
    begin
      int lat = 6;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      chk("ignored_start_latency", lat, 16);
    end
    chk("ignored_start_quotient", quotient, 16'h000E);
    chk("ignored_start_remainder", remainder, 16'h0002);

    // Start held high through DONE is taken in the following IDLE cycle.
    dividend = 16'h0009;
    divisor  = 16'h0003;
    start    = 1'b1;
    tick();
    chk("held_start_idle_busy", busy, 1'b0);
    chk("held_start_idle_done", done, 1'b0);
    tick();
    chk("held_start_accept_busy", busy, 1'b1);
    start = 1'b0;
    wait_done("held_start", 16'h0003, 16'h0003, 16'h0000, 1'b0);
    tick();

    // Reset during RUN aborts with no done pulse.
    dividend = 16'h0064;
    divisor  = 16'h0007;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quotient", quotient, 16'h0);
    chk("abort_remainder", remainder, 16'h0);
    chk("abort_dbz", div_by_zero, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("abort_no_done", done_seen, 0);
    do_op("after_abort", 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'h8000 | 16'($urandom);
        default: b = 16'($urandom);
      endcase
      model(a, b, mq, mr, mz);
      do_op($sformatf("rand%0d", i), a, b, mq, mr, mz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
